// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - PS/2 shared types, command bytes and scan codes
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SEND,
    ACK,
    WAIT_IDLE
  } state_t;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESEND   = 8'hFE;

  // Scan codes also decoded by the keyboard receiver.
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_BREAK = 8'hF0;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - 2-FF synchronizer with falling-edge detect for one PS/2 line
module ps2_line_sync (
  input  logic clock,
  input  logic reset_n,
  input  logic line,
  output logic sync,
  output logic fall
);

  logic meta;
  logic prev;

  // Reset to the idle-high level so leaving reset never looks like an edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= line;
      sync <= meta;
      prev <= sync;
    end
  end

  assign fall = prev & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter; PS2_TX_RETRY_EN enables automatic retries
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int MAX_RETRIES    = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_byte,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       nack_err,
  output logic       timeout_err
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic INH_ONE = (INHIBIT_CYCLES == 1);

  state_t      state;
  logic [7:0]  byte_q;
  logic [3:0]  bit_idx;
  logic [CW-1:0] cnt;
  logic [9:0]  frame;
  logic        clk_sync, clk_fall, data_sync, data_fall_unused;
  logic        watching, tmo_hit, nack_hit, fail, retry_ok;

  ps2_line_sync u_clk_sync (
    .clock  (clock),
    .reset_n(reset_n),
    .line   (ps2_clk_in),
    .sync   (clk_sync),
    .fall   (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .clock  (clock),
    .reset_n(reset_n),
    .line   (ps2_data_in),
    .sync   (data_sync),
    .fall   (data_fall_unused)
  );

`ifdef PS2_TX_RETRY_EN
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  logic [RW-1:0] retries;
  assign retry_ok = (int'(retries) < MAX_RETRIES);
`else
  localparam int max_retries_unused = MAX_RETRIES;
  assign retry_ok = 1'b0;
`endif

  // Bits shifted out after each device falling edge: data LSB first, parity, stop.
  assign frame    = {1'b1, odd_parity(byte_q), byte_q};
  assign watching = (state == SEND) || (state == ACK) || (state == WAIT_IDLE);
  assign tmo_hit  = watching && (cnt == TMO_LAST);
  assign nack_hit = (state == ACK) && clk_fall && data_sync && !tmo_hit;
  assign fail     = tmo_hit || nack_hit;

  assign tx_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      byte_q      <= '0;
      bit_idx     <= '0;
      cnt         <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      done        <= 1'b0;
      nack_err    <= 1'b0;
      timeout_err <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retries     <= '0;
`endif
    end else begin
      done        <= 1'b0;
      nack_err    <= 1'b0;
      timeout_err <= 1'b0;
      if (fail) begin
        if (retry_ok) begin
`ifdef PS2_TX_RETRY_EN
          retries <= retries + 1'b1;
`endif
          state       <= INHIBIT;
          cnt         <= '0;
          ps2_clk_oe  <= 1'b1;
          ps2_data_oe <= INH_ONE;
        end else begin
          state       <= IDLE;
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          timeout_err <= tmo_hit;
          nack_err    <= nack_hit;
        end
      end else begin
        case (state)
          IDLE: begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            if (tx_valid) begin
              byte_q      <= tx_byte;
              cnt         <= '0;
              ps2_clk_oe  <= 1'b1;
              ps2_data_oe <= INH_ONE;
              state       <= INHIBIT;
`ifdef PS2_TX_RETRY_EN
              retries     <= '0;
`endif
            end
          end
          INHIBIT: begin
            cnt <= cnt + 1'b1;
            if (cnt == INH_LAST) begin
              ps2_clk_oe  <= 1'b0;
              ps2_data_oe <= 1'b1;
              state       <= RTS;
            end else if (cnt == INH_LAST - 1'b1) begin
              ps2_data_oe <= 1'b1;
            end
          end
          RTS: begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= SEND;
          end
          SEND: begin
            cnt <= clk_fall ? '0 : cnt + 1'b1;
            if (clk_fall) begin
              ps2_data_oe <= ~frame[bit_idx];
              bit_idx     <= bit_idx + 1'b1;
              if (bit_idx == 4'd9) state <= ACK;
            end
          end
          ACK: begin
            cnt <= clk_fall ? '0 : cnt + 1'b1;
            if (clk_fall) state <= WAIT_IDLE;
          end
          WAIT_IDLE: begin
            cnt <= clk_fall ? '0 : cnt + 1'b1;
            if (clk_sync && data_sync) begin
              done  <= 1'b1;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with an open-drain PS/2 device model
module tb_ps2_host_tx;

  localparam int INH = 40;
  localparam int TMO = 1500;
  localparam int RET = 2;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, nack_err, timeout_err;
  logic       ps2_clk_in, ps2_data_in;

  // Open-drain bus: either side can pull low.
  assign ps2_clk_in  = ~ps2_clk_oe & dev_clk;
  assign ps2_data_in = ~ps2_data_oe & dev_data;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .MAX_RETRIES(RET)) dut (
    .clock(clock), .reset_n(reset_n), .tx_valid(tx_valid), .tx_byte(tx_byte),
    .tx_ready(tx_ready), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .busy(busy), .done(done),
    .nack_err(nack_err), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int  passed = 0, total = 0;
  int  done_n = 0, nack_n = 0, to_n = 0, phases = 0;
  int  last_to_cyc = 0, last_fall_cyc = 0, end_base = 0;
  int  run = 0;
  bit  dseen = 1'b0;
  bit  started = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Expected line bits as the device samples them: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = ($countones(b) % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // Per-cycle checks of the rules that hold in every state.
  always @(negedge clock) begin
    if (started) begin
      check("ready_vs_busy", 32'(tx_ready), 32'(!busy));
      check("single_pulse", 32'((32'(done) + 32'(nack_err) + 32'(timeout_err)) <= 1), 32'd1);
      if (done || nack_err || timeout_err)
        check("released_on_end", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
      if (done) done_n++;
      if (nack_err) nack_n++;
      if (timeout_err) begin
        to_n++;
        last_to_cyc = cyc;
      end
      if (ps2_clk_oe) begin
        run++;
        if (ps2_data_oe && !dseen) begin
          dseen = 1'b1;
          check("data_oe_last_inhibit_cycle", 32'(run), 32'(INH));
        end
      end else if (run != 0) begin
        check("inhibit_len", 32'(run), 32'(INH));
        check("start_bit_driven", 32'(ps2_data_oe), 32'd1);
        phases++;
        run = 0;
        dseen = 1'b0;
      end
    end
  end

  task automatic dev_xfer(input int nfalls, input bit ack_val, input int half,
                          output logic [10:0] bits);
    int n = 0;
    bits = '0;
    while (!(ps2_clk_in === 1'b1 && ps2_data_in === 1'b0) && n < 4 * TMO) begin
      step();
      n++;
    end
    check("rts_seen", 32'(n < 4 * TMO), 32'd1);
    if (n >= 4 * TMO) return;
    repeat (half) step();
    bits[0] = ps2_data_in;
    for (int i = 0; i < nfalls; i++) begin
      if (i == 10) dev_data = ack_val;
      dev_clk = 1'b0;
      last_fall_cyc = cyc;
      repeat (half) step();
      dev_clk = 1'b1;
      dev_data = 1'b1;
      if (i < 10) bits[i+1] = ps2_data_in;
      repeat (half) step();
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    while (tx_ready !== 1'b1 && n < 1000) begin
      step();
      n++;
    end
    check("ready_before_send", 32'(tx_ready), 32'd1);
    end_base = done_n + nack_n + to_n;
    tx_valid = 1'b1;
    tx_byte = b;
    step();
    tx_valid = 1'b0;
    tx_byte = 8'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic wait_end();
    int n = 0;
    while ((done_n + nack_n + to_n) == end_base && n < 8 * TMO) begin
      step();
      n++;
    end
    check("outcome_seen", 32'(n < 8 * TMO), 32'd1);
    step();
    check("ready_after_end", 32'(tx_ready), 32'd1);
  endtask

  task automatic xfer_ok(input logic [7:0] b, output logic [10:0] bits);
    int d0, n0, t0, p0;
    d0 = done_n; n0 = nack_n; t0 = to_n; p0 = phases;
    send(b);
    dev_xfer(11, 1'b0, 32'($urandom_range(5, 12)), bits);
    wait_end();
    check("frame_vs_model", 32'(bits), 32'(frame_of(b)));
    check("done_once", 32'(done_n - d0), 32'd1);
    check("no_nack", 32'(nack_n - n0), 32'd0);
    check("no_timeout", 32'(to_n - t0), 32'd0);
    check("one_inhibit", 32'(phases - p0), 32'd1);
  endtask

  initial begin
    logic [10:0] bits;
    int d0, n0, t0, p0;

    check("model_ed", 32'(frame_of(8'hED)), 32'(11'b11111011010));
    check("model_f4", 32'(frame_of(8'hF4)), 32'(11'b10111101000));

    repeat (3) step();
    check("reset_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("reset_data_oe", 32'(ps2_data_oe), 32'd0);
    check("reset_pulses", 32'({done, nack_err, timeout_err}), 32'd0);
    reset_n = 1'b1;
    step();
    started = 1'b1;
    check("reset_ready", 32'(tx_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);

    xfer_ok(8'hED, bits);
    check("ed_literal", 32'(bits), 32'(11'b11111011010));
    xfer_ok(8'hF4, bits);
    check("f4_parity", 32'(bits[9]), 32'd0);
    check("f4_data", 32'(bits[8:1]), 32'h0F4);

    // Device answers with ACK = 1.
    d0 = done_n; n0 = nack_n; p0 = phases;
    send(8'($urandom));
`ifdef PS2_TX_RETRY_EN
    repeat (RET + 1) dev_xfer(11, 1'b1, 8, bits);
    wait_end();
    check("nack_inhibits", 32'(phases - p0), 32'(RET + 1));
`else
    dev_xfer(11, 1'b1, 8, bits);
    wait_end();
`endif
    check("nack_once", 32'(nack_n - n0), 32'd1);
    check("nack_no_done", 32'(done_n - d0), 32'd0);

    // Device stops clocking after bit 3.
    d0 = done_n; t0 = to_n; p0 = phases;
    send(8'($urandom));
    dev_xfer(4, 1'b0, 7, bits);
    wait_end();
    check("timeout_once", 32'(to_n - t0), 32'd1);
    check("timeout_no_done", 32'(done_n - d0), 32'd0);
`ifdef PS2_TX_RETRY_EN
    check("timeout_inhibits", 32'(phases - p0), 32'(RET + 1));
`else
    // Two synchronizer stages plus the registered pulse after the counted cycles.
    check("timeout_latency", 32'(last_to_cyc - last_fall_cyc), 32'(TMO + 3));
`endif

    // Reset in the middle of SEND at k = 5.
    d0 = done_n; n0 = nack_n; t0 = to_n;
    send(8'h5A);
    dev_xfer(5, 1'b0, 6, bits);
    reset_n = 1'b0;
    step();
    check("midreset_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    step();
    reset_n = 1'b1;
    step();
    check("midreset_ready", 32'(tx_ready), 32'd1);
    check("midreset_no_pulse", 32'((done_n - d0) + (nack_n - n0) + (to_n - t0)), 32'd0);
    xfer_ok(8'hFF, bits);
    check("ff_literal", 32'(bits), 32'(11'b11111111110));

`ifdef PS2_TX_RETRY_EN
    d0 = done_n; n0 = nack_n; p0 = phases;
    send(8'($urandom));
    dev_xfer(11, 1'b1, 9, bits);
    dev_xfer(11, 1'b1, 9, bits);
    dev_xfer(11, 1'b0, 9, bits);
    wait_end();
    check("retry_inhibits", 32'(phases - p0), 32'd3);
    check("retry_done", 32'(done_n - d0), 32'd1);
    check("retry_no_nack", 32'(nack_n - n0), 32'd0);
`endif

    for (int r = 0; r < 6; r++) xfer_ok(8'($urandom), bits);

    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not end, checks %0d/%0d", passed, total);
    $fatal(1);
  end

endmodule
